// File: rtl/itrx_spim_initiator.sv
// SPI mode-0 initiator: one MSB-first DATA_W-bit frame per accepted start.
// SCLK half-period is (clk_div+1) clk cycles, latched when the frame starts.
module itrx_spim_initiator #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DIV_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DIV_W-1:0]  clk_div,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data,
    output logic              sclk,
    output logic              cs_n,
    output logic              mosi,
    input  logic              miso
);

    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] tx_sr_q, tx_sr_d;
    logic [DATA_W-1:0] rx_sr_q, rx_sr_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [DIV_W-1:0]  div_rld_q, div_rld_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              phase_q, phase_d;
    logic              sclk_q, sclk_d;
    logic              cs_n_q, cs_n_d;
    logic              mosi_q, mosi_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            tx_sr_q   <= '0;
            rx_sr_q   <= '0;
            div_q     <= '0;
            div_rld_q <= '0;
            cnt_q     <= '0;
            phase_q   <= 1'b0;
            sclk_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            mosi_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rx_data_q <= '0;
        end else begin
            state_q   <= state_d;
            tx_sr_q   <= tx_sr_d;
            rx_sr_q   <= rx_sr_d;
            div_q     <= div_d;
            div_rld_q <= div_rld_d;
            cnt_q     <= cnt_d;
            phase_q   <= phase_d;
            sclk_q    <= sclk_d;
            cs_n_q    <= cs_n_d;
            mosi_q    <= mosi_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rx_data_q <= rx_data_d;
        end
    end

    // Divider ticks once per SCLK half-period; each tick advances the frame.
    always_comb begin
        state_d   = state_q;
        tx_sr_d   = tx_sr_q;
        rx_sr_d   = rx_sr_q;
        div_d     = div_q;
        div_rld_d = div_rld_q;
        cnt_d     = cnt_q;
        phase_d   = phase_q;
        sclk_d    = sclk_q;
        cs_n_d    = cs_n_q;
        mosi_d    = mosi_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        rx_data_d = rx_data_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    tx_sr_d   = tx_data;
                    rx_sr_d   = '0;
                    div_rld_d = clk_div;
                    div_d     = clk_div;
                    cnt_d     = '0;
                    cs_n_d    = 1'b0;
                    busy_d    = 1'b1;
                    mosi_d    = tx_data[DATA_W-1];
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                if (div_q == '0) begin
                    div_d   = div_rld_q;
                    sclk_d  = 1'b1;
                    rx_sr_d = {rx_sr_q[DATA_W-2:0], miso};
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = SHIFT;
                end else begin
                    div_d = div_q - DIV_W'(1);
                end
            end
            SHIFT: begin
                if (div_q == '0) begin
                    div_d = div_rld_q;
                    if (sclk_q) begin
                        sclk_d = 1'b0;
                        if (cnt_q == CNT_W'(DATA_W)) begin
                            phase_d = 1'b0;
                            state_d = HOLD;
                        end else begin
                            mosi_d  = tx_sr_q[DATA_W-2];
                            tx_sr_d = {tx_sr_q[DATA_W-2:0], 1'b0};
                        end
                    end else begin
                        sclk_d  = 1'b1;
                        rx_sr_d = {rx_sr_q[DATA_W-2:0], miso};
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end else begin
                    div_d = div_q - DIV_W'(1);
                end
            end
            HOLD: begin
                // Trailing idle of one full SCLK period before CS_N is released.
                if (div_q == '0) begin
                    div_d = div_rld_q;
                    if (phase_q) begin
                        cs_n_d    = 1'b1;
                        mosi_d    = 1'b0;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                        rx_data_d = rx_sr_q;
                        state_d   = IDLE;
                    end else begin
                        phase_d = 1'b1;
                    end
                end else begin
                    div_d = div_q - DIV_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign rx_data = rx_data_q;
    assign sclk    = sclk_q;
    assign cs_n    = cs_n_q;
    assign mosi    = mosi_q;

endmodule

// File: tb/tb_itrx_spim_initiator.sv
// Directed bench for itrx_spim_initiator (DATA_W=8): frame timing, MOSI order,
// MISO capture via an expected-word queue, start filtering and async reset.
module tb_itrx_spim_initiator;

    localparam int unsigned DW = 8;
    localparam int unsigned VW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [VW-1:0] clk_div;
    logic          start;
    logic [DW-1:0] tx_data;
    logic          busy, done, sclk, cs_n, mosi, miso;
    logic [DW-1:0] rx_data;
    logic          loop_en;
    logic          miso_fix;

    int vectors = 0;
    int errors  = 0;
    logic [DW-1:0] exp_q[$];

    assign miso = loop_en ? mosi : miso_fix;

    always #5 clk = ~clk;

    itrx_spim_initiator #(.DATA_W(DW), .DIV_W(VW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .clk_div (clk_div),
        .start   (start),
        .tx_data (tx_data),
        .busy    (busy),
        .done    (done),
        .rx_data (rx_data),
        .sclk    (sclk),
        .cs_n    (cs_n),
        .mosi    (mosi),
        .miso    (miso)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_rx(input string tag);
        logic [DW-1:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_queue_empty"}, 64'd1, 64'd0);
        end else begin
            e = exp_q.pop_front();
            check(tag, 64'(rx_data), 64'(e));
        end
    endtask

    // Runs one frame and checks its timing. h is the half-period in force for this
    // frame; inj_j / div_j are sample indices at which to poke start or clk_div.
    task automatic run_frame(input string tag, input logic [DW-1:0] tx, input int h,
                             input bit lb, input bit mf,
                             input int inj_j, input logic [DW-1:0] inj_tx,
                             input int div_j, input logic [VW-1:0] new_div);
        int j, last_t, rises, first_rise, dones, done_j, bad, limit;
        logic prev_sclk;
        logic [DW-1:0] mosi_word;
        j = 0; last_t = 0; rises = 0; first_rise = -1; dones = 0; done_j = -1;
        bad = 0; prev_sclk = 1'b0; mosi_word = '0;
        limit = 2 * h * (DW + 1) + 3;
        @(negedge clk);
        loop_en = lb; miso_fix = mf; tx_data = tx;
        clk_div = VW'(h - 1); start = 1'b1;
        exp_q.push_back(lb ? tx : {DW{mf}});
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, "_cs_low_c1"}, 64'({cs_n, busy}), 64'(2'b01));
        while (j < limit) begin
            if (j == inj_j) begin
                start = 1'b1; tx_data = inj_tx;
            end else begin
                start = 1'b0;
            end
            if (j == div_j) clk_div = new_div;
            if (sclk !== prev_sclk) begin
                if (j - last_t != h) bad++;
                last_t = j;
                if (sclk) begin
                    rises++;
                    if (rises == 1) first_rise = j;
                    mosi_word = {mosi_word[DW-2:0], mosi};
                end
            end
            prev_sclk = sclk;
            if (done) begin
                dones++;
                if (dones == 1) begin
                    done_j = j;
                    check_rx({tag, "_rx"});
                end
            end
            @(posedge clk); #1;
            j++;
        end
        start = 1'b0;
        check({tag, "_first_rise"}, 64'(first_rise + 1), 64'(1 + h));
        check({tag, "_rises"}, 64'(rises), 64'(DW));
        check({tag, "_half_period"}, 64'(bad), 64'd0);
        check({tag, "_done_cycle"}, 64'(done_j + 1), 64'(1 + 2 * h * (DW + 1)));
        check({tag, "_done_count"}, 64'(dones), 64'd1);
        check({tag, "_mosi_seq"}, 64'(mosi_word), 64'(tx));
        check({tag, "_idle"}, 64'({cs_n, busy, sclk, mosi}), 64'(4'b1000));
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; tx_data = '0; clk_div = '0;
        loop_en = 1'b0; miso_fix = 1'b0;
        #23;
        check("reset_outs", 64'({busy, done, sclk, cs_n, mosi}), 64'(5'b00010));
        check("reset_rx", 64'(rx_data), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Loopback, maximum SCLK rate.
        run_frame("lb_a5", 8'hA5, 1, 1'b1, 1'b0, -1, 8'h00, -1, 8'd0);
        // Slow SCLK, MISO tied high, all-zero transmit.
        run_frame("div3_ff", 8'h00, 4, 1'b0, 1'b1, -1, 8'h00, -1, 8'd0);
        // Start mid-frame with different data must be ignored.
        run_frame("ign_start", 8'h96, 1, 1'b1, 1'b0, 9, 8'h5A, -1, 8'd0);
        // clk_div change mid-frame only affects the following frame.
        run_frame("div_chg", 8'hC3, 2, 1'b1, 1'b0, -1, 8'h00, 3, 8'd5);
        run_frame("div_next", 8'h81, 6, 1'b0, 1'b0, -1, 8'h00, -1, 8'd0);

        // Start held high: back-to-back frames with a single idle CS_N cycle.
        @(negedge clk);
        loop_en = 1'b1; tx_data = 8'h3C; clk_div = '0; start = 1'b1;
        for (int f = 0; f < 3; f++) begin
            int w;
            exp_q.push_back(8'h3C);
            w = 0;
            @(posedge clk); #1;
            while (!done && w < 100) begin
                @(posedge clk); #1;
                w++;
            end
            check("b2b_done_seen", 64'(done), 64'd1);
            check("b2b_cs_in_done", 64'(cs_n), 64'd1);
            check_rx("b2b_rx");
            if (f == 2) start = 1'b0;
            @(posedge clk); #1;
            check("b2b_cs_next", 64'(cs_n), (f == 2) ? 64'd1 : 64'd0);
        end
        repeat (3) @(posedge clk);
        #1;

        // Asynchronous reset in the middle of a frame.
        @(negedge clk);
        loop_en = 1'b1; tx_data = 8'hFF; clk_div = '0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_outs", 64'({cs_n, sclk, mosi, busy, done}), 64'(5'b10000));
        check("rst_mid_rx", 64'(rx_data), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_hold_done", 64'(done), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        run_frame("post_rst", 8'h5B, 1, 1'b1, 1'b0, -1, 8'h00, -1, 8'd0);

        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
